// File: rtl/nic8_pkg.sv
// Shared types for the nic8 Q-register output path: formatter and UART state
// encodings, the ASCII digit base and one double-dabble step.
package nic8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND_H,
        SEND_T,
        SEND_O,
        SEND_EOL
    } fmt_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // Layout {hundreds[19:16], tens[15:12], ones[11:8], binary[7:0]}:
    // correct every BCD digit >= 5 by +3, then shift the whole vector left once.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx8n1.sv
// UART 8N1 transmitter: start bit, eight data bits LSB first, stop bit,
// each bit held for CLKS_PER_BIT clocks.
module uart_tx8n1
    import nic8_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       resetBar,
    input  logic [7:0] charData,
    input  logic       charValid,
    output logic       charReady,
    output logic       txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Handshake: a byte transfers on a posedge where charValid && charReady;
    // charReady is high exactly while the transmitter is idle.
    assign charReady = (state == U_IDLE);

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state   <= U_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                U_IDLE: begin
                    if (charValid) begin
                        shreg   <= charData;
                        txd     <= 1'b0;
                        bit_cnt <= '0;
                        state   <= U_START;
                    end
                end
                U_START: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                        state   <= U_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= U_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        state   <= U_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/qout_uart_tx.sv
// Captures every Q load into a FIFO, formats it as "%03d" plus EOL_CHAR and
// streams the text out over a UART 8N1 line.
module qout_uart_tx
    import nic8_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
    input  logic                        clk,
    input  logic                        resetBar,
    input  logic                        qWrite,
    input  logic [7:0]                  qData,
    output logic                        txd,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            push;
    logic            pop;

    fmt_state_t  fmt_state;
    logic [19:0] dd;
    logic [19:0] dd_next;
    logic [2:0]  conv_cnt;
    logic        char_valid;
    logic [7:0]  char_byte;
    logic        char_ready;

    assign pop  = (fmt_state == IDLE) && (count != '0);
    // A full FIFO still accepts a write on the edge that frees a slot.
    assign push = qWrite && ((count != FULL_CNT) || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= qData;
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (qWrite && !push) overflow <= 1'b1;
        end
    end

    always_comb begin
        dd_next = dd_step(dd);
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            fmt_state  <= IDLE;
            dd         <= '0;
            conv_cnt   <= '0;
            char_valid <= 1'b0;
            char_byte  <= '0;
        end else begin
            case (fmt_state)
                IDLE: begin
                    if (pop) begin
                        dd        <= {12'd0, mem[rd_ptr]};
                        conv_cnt  <= '0;
                        fmt_state <= CONV;
                    end
                end
                CONV: begin
                    dd       <= dd_next;
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == 3'd7) begin
                        char_valid <= 1'b1;
                        char_byte  <= ASCII_ZERO + {4'd0, dd_next[19:16]};
                        fmt_state  <= SEND_H;
                    end
                end
                SEND_H: begin
                    if (char_ready) begin
                        char_byte <= ASCII_ZERO + {4'd0, dd[15:12]};
                        fmt_state <= SEND_T;
                    end
                end
                SEND_T: begin
                    if (char_ready) begin
                        char_byte <= ASCII_ZERO + {4'd0, dd[11:8]};
                        fmt_state <= SEND_O;
                    end
                end
                SEND_O: begin
                    if (char_ready) begin
                        char_byte <= EOL_CHAR;
                        fmt_state <= SEND_EOL;
                    end
                end
                SEND_EOL: begin
                    if (char_ready) begin
                        char_valid <= 1'b0;
                        fmt_state  <= IDLE;
                    end
                end
                default: fmt_state <= IDLE;
            endcase
        end
    end

    uart_tx8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk      (clk),
        .resetBar (resetBar),
        .charData (char_byte),
        .charValid(char_valid),
        .charReady(char_ready),
        .txd      (txd)
    );

    assign fifoCount = count;
    assign busy      = (count != '0) || (fmt_state != IDLE) || !char_ready;

endmodule

// File: tb/tb_qout_uart_tx.sv
// Directed bench for qout_uart_tx: a CLKS_PER_BIT=4 instance for formatting,
// FIFO and reset scenarios, and a CLKS_PER_BIT=16 instance for bit timing.
module tb_qout_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB16 = 16;

    logic       clk;
    logic       rst_n;
    logic       q_write;
    logic [7:0] q_data;
    logic       txd;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    logic       rst_n16;
    logic       q_write16;
    logic [7:0] q_data16;
    logic       txd16;
    logic       busy16;
    logic       overflow16;
    logic [2:0] fifo_count16;

    int         tests_run;
    int         tests_failed;
    int         cyc;
    int         rx_frame_err;
    int         peak;
    bit         track_peak;
    logic [7:0] mon_byte;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    qout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .EOL_CHAR(8'h0A)) u_dut (
        .clk      (clk),
        .resetBar (rst_n),
        .qWrite   (q_write),
        .qData    (q_data),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow),
        .fifoCount(fifo_count)
    );

    qout_uart_tx #(.CLKS_PER_BIT(CPB16), .FIFO_DEPTH(4), .EOL_CHAR(8'h0A)) u_dut16 (
        .clk      (clk),
        .resetBar (rst_n16),
        .qWrite   (q_write16),
        .qData    (q_data16),
        .txd      (txd16),
        .busy     (busy16),
        .overflow (overflow16),
        .fifoCount(fifo_count16)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (track_peak && int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- UART receiver (CPB=4 instance) ----------------
    initial begin
        rx_frame_err = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    mon_byte[i] = txd;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) rx_frame_err++;
                rx_q.push_back(mon_byte);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_vals(input int n, input logic [7:0] v0, input logic [7:0] step);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            q_write = 1'b1;
            q_data  = v0 + 8'(i) * step;
            @(negedge clk);
        end
        q_write = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int bound);
        int k;
        k = 0;
        while (rx_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; rst_n16 = 1'b0;
        q_write = 1'b0; q_data = '0; q_write16 = 1'b0; q_data16 = '0;
        repeat (3) @(negedge clk);
        tests_run += 8;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b want 1", txd); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        if (txd16 !== 1'b1) begin tests_failed++; $display("FAIL reset_txd16: got %b want 1", txd16); end
        if (busy16 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy16: got %b want 0", busy16); end
        if (overflow16 !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf16: got %b want 0", overflow16); end
        if (fifo_count16 !== 3'd0) begin tests_failed++; $display("FAIL reset_count16: got %0d want 0", fifo_count16); end
        rst_n = 1'b1; rst_n16 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] e[4];
        int w0;
        e = '{8'h30, 8'h34, 8'h32, 8'h0A};
        rx_q.delete();
        write_vals(1, 8'd42, 8'd0);
        w0 = cyc;
        wait_rx(4, 400);
        tests_run++;
        if (rx_q.size() != 4) begin tests_failed++; $display("FAIL single_len: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rx_q[i] !== e[i]) begin tests_failed++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], e[i]); end
        end
        // last stop bit spans posedges w0+169..w0+173
        while (cyc < w0 + 172) @(negedge clk);
        tests_run += 3;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_stop: got %b want 1", busy); end
        @(negedge clk);
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL single_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e[8];
        e = '{8'h30, 8'h30, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
        wait_idle();
        rx_q.delete();
        peak = 0;
        track_peak = 1'b1;
        write_vals(2, 8'd0, 8'd255);
        tests_run++;
        if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count: got %0d want 1", fifo_count); end
        wait_rx(8, 800);
        track_peak = 1'b0;
        tests_run += 2;
        if (peak != 1) begin tests_failed++; $display("FAIL b2b_peak: got %0d want 1", peak); end
        if (rx_q.size() != 8) begin tests_failed++; $display("FAIL b2b_len: got %0d want 8", rx_q.size()); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (rx_q[i] !== e[i]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], e[i]); end
        end
    endtask

    task automatic test_pop_edge();
        int w0;
        wait_idle();
        rx_q.delete();
        exp_q.delete();
        for (int v = 1; v <= 6; v++) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h32);
            exp_q.push_back(8'h30 + 8'(v));
            exp_q.push_back(8'h0A);
        end
        write_vals(5, 8'd21, 8'd1);
        w0 = cyc - 4;
        tests_run++;
        if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL pop_full: got %0d want 4", fifo_count); end
        // first value's EOL handshakes at w0+133, so the next pop is edge w0+134
        while (cyc < w0 + 133) @(negedge clk);
        tests_run += 2;
        if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL pop_pre_count: got %0d want 4", fifo_count); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pop_pre_ovf: got %b want 0", overflow); end
        q_write = 1'b1;
        q_data  = 8'd26;
        @(negedge clk);
        q_write = 1'b0;
        tests_run += 2;
        if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL pop_post_count: got %0d want 4", fifo_count); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pop_post_ovf: got %b want 0", overflow); end
        wait_rx(24, 1500);
        tests_run++;
        if (rx_q.size() != 24) begin tests_failed++; $display("FAIL pop_len: got %0d want 24", rx_q.size()); end
        for (int i = 0; i < 24; i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL pop_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        wait_idle();
        rx_q.delete();
        exp_q.delete();
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h31);
            exp_q.push_back(8'h30 + 8'(v));
            exp_q.push_back(8'h0A);
        end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_start: got %b want 0", overflow); end
        write_vals(6, 8'd10, 8'd1);
        tests_run += 2;
        if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        wait_rx(20, 1200);
        repeat (200) @(negedge clk);
        tests_run += 3;
        if (rx_q.size() != 20) begin tests_failed++; $display("FAIL ovf_len: got %0d want 20", rx_q.size()); end
        if (rx_frame_err != 0) begin tests_failed++; $display("FAIL ovf_frame: got %0d errors want 0", rx_frame_err); end
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e[4];
        int w0;
        e = '{8'h30, 8'h39, 8'h39, 8'h0A};
        wait_idle();
        write_vals(1, 8'd7, 8'd0);
        w0 = cyc;
        // second character '0' is in data bit 1 (a zero) here
        while (cyc < w0 + 60) @(negedge clk);
        tests_run += 2;
        if (txd !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pre_txd: got %b want 0", txd); end
        #1;
        rst_n = 1'b0;
        #1;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL rstmid_async_txd: got %b want 1", txd); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run += 3;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
        repeat (60) @(negedge clk);
        rx_q.delete();
        rx_frame_err = 0;
        write_vals(1, 8'd99, 8'd0);
        wait_rx(4, 400);
        tests_run += 2;
        if (rx_q.size() != 4) begin tests_failed++; $display("FAIL rstmid_len: got %0d want 4", rx_q.size()); end
        if (rx_frame_err != 0) begin tests_failed++; $display("FAIL rstmid_frame: got %0d errors want 0", rx_frame_err); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rx_q[i] !== e[i]) begin tests_failed++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], e[i]); end
        end
    endtask

    task automatic test_bit_timing();
        // run lengths of txd for "001\n" at 16 clk/bit; stop runs include the handshake cycle
        int exp_runs[19];
        int k;
        int len;
        logic cur;
        exp_runs = '{80, 32, 32, 17, 80, 32, 32, 17, 16, 16, 48, 32, 32, 17, 32, 16, 16, 16, 64};
        @(negedge clk);
        q_write16 = 1'b1;
        q_data16  = 8'd1;
        @(negedge clk);
        q_write16 = 1'b0;
        k = 0;
        while (txd16 !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (txd16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL timing_start: txd16=%b, no start bit within 100 cycles", txd16);
        end else begin
            cur = txd16;
            for (int i = 0; i < 19; i++) begin
                len = 1;
                @(negedge clk);
                while (txd16 === cur && len < 400) begin
                    len++;
                    @(negedge clk);
                end
                tests_run++;
                if (len != exp_runs[i]) begin tests_failed++; $display("FAIL timing_run%0d: got %0d cycles want %0d", i, len, exp_runs[i]); end
                cur = txd16;
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        track_peak   = 1'b0;
        peak         = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_pop_edge();
        test_overflow();
        test_reset_midframe();
        test_bit_timing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
